// File: rtl/dmem_if.sv
// ============================================================================
// Module      : dmem_if
// Description : Load/store request/response channel between core and memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : Fixed-latency handshaked RV64 data memory (one request in flight).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
    parameter int DEPTH_DWORDS = 512,
    parameter int LATENCY      = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    dmem_if.slave     bus
);

    localparam int          c_AW       = (DEPTH_DWORDS > 1) ? $clog2(DEPTH_DWORDS) : 1;
    localparam logic [63:0] c_BYTES    = 64'(DEPTH_DWORDS) << 3;
    localparam logic [3:0]  c_CNT_INIT = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);
    localparam bit          c_DIRECT   = (LATENCY == 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [2:0]  r_funct3;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] r_rdata;
    logic        r_err;
    logic [63:0] r_mem [DEPTH_DWORDS];

    logic        w_req_ready;
    logic        w_accept;
    logic        w_commit;
    logic        w_write;
    logic [2:0]  w_funct3;
    logic [63:0] w_addr;
    logic [63:0] w_wdata;
    logic [2:0]  w_size_m1;
    logic [7:0]  w_bytes;
    logic        w_misalign;
    logic        w_oob;
    logic        w_badop;
    logic        w_err;
    logic [c_AW-1:0] w_idx;
    logic [5:0]  w_bitoff;
    logic [63:0] w_word;
    logic [63:0] w_shr;
    logic [63:0] w_load;
    logic [7:0]  w_bmask;
    logic [63:0] w_wmask;
    logic [63:0] w_merged;

    assign w_req_ready = (r_state == c_ST_IDLE) && !rst;
    assign w_accept    = bus.req_valid && w_req_ready;

    // With LATENCY 1 the access commits on the accept edge, so it must see the live request.
    assign w_write  = (r_state == c_ST_IDLE) ? bus.req_write  : r_write;
    assign w_funct3 = (r_state == c_ST_IDLE) ? bus.req_funct3 : r_funct3;
    assign w_addr   = (r_state == c_ST_IDLE) ? bus.req_addr   : r_addr;
    assign w_wdata  = (r_state == c_ST_IDLE) ? bus.req_wdata  : r_wdata;

    assign w_commit = ((r_state == c_ST_IDLE) && w_accept && c_DIRECT) ||
                      ((r_state == c_ST_WAIT) && (r_cnt == 4'd0));

    always_comb begin
        w_size_m1 = 3'd0;
        w_bytes   = 8'h01;
        case (w_funct3[1:0])
            2'd0: begin w_size_m1 = 3'd0; w_bytes = 8'h01; end
            2'd1: begin w_size_m1 = 3'd1; w_bytes = 8'h03; end
            2'd2: begin w_size_m1 = 3'd3; w_bytes = 8'h0F; end
            default: begin w_size_m1 = 3'd7; w_bytes = 8'hFF; end
        endcase
    end

    // The first term short-circuits huge addresses so the end-address add cannot wrap into range.
    assign w_misalign = |(w_addr[2:0] & w_size_m1);
    assign w_oob      = (w_addr >= c_BYTES) || ((w_addr + {61'd0, w_size_m1}) >= c_BYTES);
    assign w_badop    = w_write ? w_funct3[2] : (w_funct3 == 3'd7);
    assign w_err      = w_misalign || w_oob || w_badop;

    assign w_idx    = w_addr[c_AW+2:3];
    assign w_bitoff = {w_addr[2:0], 3'b000};
    assign w_word   = r_mem[w_idx];
    assign w_shr    = w_word >> w_bitoff;

    always_comb begin
        w_load = 64'd0;
        case (w_funct3)
            3'd0: w_load = {{56{w_shr[7]}},  w_shr[7:0]};
            3'd1: w_load = {{48{w_shr[15]}}, w_shr[15:0]};
            3'd2: w_load = {{32{w_shr[31]}}, w_shr[31:0]};
            3'd3: w_load = w_shr;
            3'd4: w_load = {56'd0, w_shr[7:0]};
            3'd5: w_load = {48'd0, w_shr[15:0]};
            3'd6: w_load = {32'd0, w_shr[31:0]};
            default: w_load = 64'd0;
        endcase
    end

    assign w_bmask = w_bytes << w_addr[2:0];

    always_comb begin
        w_wmask = 64'd0;
        for (int b = 0; b < 8; b++) begin
            w_wmask[b*8 +: 8] = {8{w_bmask[b]}};
        end
    end

    assign w_merged = (w_word & ~w_wmask) | ((w_wdata << w_bitoff) & w_wmask);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 64'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        if (c_DIRECT) begin
                            r_state <= c_ST_RESP;
                        end else begin
                            r_cnt   <= c_CNT_INIT;
                            r_state <= c_ST_WAIT;
                        end
                    end
                end
                c_ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= c_ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_ST_RESP: begin
                    if (bus.resp_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
            if (w_commit) begin
                r_err   <= w_err;
                r_rdata <= (w_err || w_write) ? 64'd0 : w_load;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_write  <= bus.req_write;
            r_funct3 <= bus.req_funct3;
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_commit && w_write && !w_err) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = (r_state == c_ST_RESP);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_error = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module      : tb_dmem_responder
// Description : Scoreboard bench for dmem_responder at LATENCY 2 and LATENCY 1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    localparam int c_DEPTH = 512;
    localparam int c_BYTES = c_DEPTH * 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        t_sel    = 1'b0;
    logic        t_valid  = 1'b0;
    logic        t_write  = 1'b0;
    logic [2:0]  t_funct3 = 3'd0;
    logic [63:0] t_addr   = 64'd0;
    logic [63:0] t_wdata  = 64'd0;
    logic        t_rr     = 1'b0;

    dmem_if ifa ();
    dmem_if ifb ();

    assign ifa.req_valid  = t_valid && !t_sel;
    assign ifb.req_valid  = t_valid && t_sel;
    assign ifa.req_write  = t_write;   assign ifb.req_write  = t_write;
    assign ifa.req_funct3 = t_funct3;  assign ifb.req_funct3 = t_funct3;
    assign ifa.req_addr   = t_addr;    assign ifb.req_addr   = t_addr;
    assign ifa.req_wdata  = t_wdata;   assign ifb.req_wdata  = t_wdata;
    assign ifa.resp_ready = t_rr;      assign ifb.resp_ready = t_rr;

    dmem_responder #(.DEPTH_DWORDS(c_DEPTH), .LATENCY(2)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
    dmem_responder #(.DEPTH_DWORDS(c_DEPTH), .LATENCY(1)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

    wire        w_rdy = t_sel ? ifb.req_ready  : ifa.req_ready;
    wire        w_rv  = t_sel ? ifb.resp_valid : ifa.resp_valid;
    wire [63:0] w_rd  = t_sel ? ifb.resp_rdata : ifa.resp_rdata;
    wire        w_er  = t_sel ? ifb.resp_error : ifa.resp_error;

    typedef struct packed {
        logic [63:0] rd;
        logic        err;
        logic [3:0]  lat;
    } exp_t;

    exp_t        sb[$];
    int          n_total = 0;
    int          n_bad   = 0;
    logic [7:0]  m [c_BYTES];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Byte-array reference for the LATENCY-2 instance.
    task automatic model_access(input logic w, input logic [2:0] f3, input logic [63:0] a,
                                input logic [63:0] wd, output logic [63:0] rd, output logic err);
        int sz;
        logic [63:0] v;
        sz  = 1 << f3[1:0];
        err = (w && f3 > 3'd3) || (!w && f3 == 3'd7) || ((a % 64'(sz)) != 64'd0) ||
              (a > 64'(c_BYTES - sz));
        rd  = 64'd0;
        if (!err) begin
            if (w) begin
                for (int i = 0; i < sz; i++) m[int'(a) + i] = wd[8*i +: 8];
            end else begin
                v = 64'd0;
                for (int i = 0; i < sz; i++) v[8*i +: 8] = m[int'(a) + i];
                if (f3 < 3'd3 && v[8*sz-1]) begin
                    for (int i = 8*sz; i < 64; i++) v[i] = 1'b1;
                end
                rd = v;
            end
        end
    endtask

    task automatic txn(input logic s, input logic w, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input logic [63:0] erd, input logic eerr,
                       input int hold, input bit use_model);
        exp_t e;
        logic [63:0] mrd;
        logic merr;
        int n;
        e.rd = erd; e.err = eerr; e.lat = s ? 4'd1 : 4'd2;
        if (!s) begin
            model_access(w, f3, a, wd, mrd, merr);
            if (use_model) begin e.rd = mrd; e.err = merr; end
        end
        sb.push_back(e);
        @(negedge clk);
        t_sel = s; t_write = w; t_funct3 = f3; t_addr = a; t_wdata = wd;
        t_valid = 1'b1; t_rr = (hold == 0);
        n = 0;
        while (!w_rdy && n < 50) begin @(negedge clk); n++; end
        if (!w_rdy) begin
            check("req_ready_timeout", 64'(w_rdy), 64'd1);
            t_valid = 1'b0;
            void'(sb.pop_front());
            return;
        end
        @(posedge clk); #1;
        t_valid = 1'b0; t_write = ~w; t_funct3 = ~f3; t_addr = ~a; t_wdata = ~wd;
        n = 1;
        while (!w_rv && n < 40) begin @(posedge clk); #1; n++; end
        e = sb.pop_front();
        check("latency", 64'(n), 64'(e.lat));
        check("rdata", w_rd, e.rd);
        check("error", 64'(w_er), 64'(e.err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(w_rv), 64'd1);
            check("hold_rdata", w_rd, e.rd);
            check("hold_error", 64'(w_er), 64'(e.err));
            check("hold_req_ready", 64'(w_rdy), 64'd0);
            t_valid = (i == 1);
            t_write = 1'b1; t_funct3 = 3'd3; t_addr = 64'h10; t_wdata = 64'hDEAD_DEAD_DEAD_DEAD;
        end
        if (hold > 0) begin
            @(negedge clk);
            t_valid = 1'b0; t_rr = 1'b1;
        end
        @(posedge clk); #1;
        check("post_hs_valid", 64'(w_rv), 64'd0);
        check("post_hs_ready", 64'(w_rdy), 64'd1);
        t_rr = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ra, rw;
        logic [2:0]  rf;
        logic        rwr;
        for (int i = 0; i < c_BYTES; i++) m[i] = 8'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready_a", 64'(ifa.req_ready), 64'd0);
        check("rst_ready_b", 64'(ifb.req_ready), 64'd0);
        check("rst_valid_a", 64'(ifa.resp_valid), 64'd0);
        check("rst_rdata_a", ifa.resp_rdata, 64'd0);
        check("rst_error_a", 64'(ifa.resp_error), 64'd0);
        check("rst_valid_b", 64'(ifb.resp_valid), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("idle_ready_a", 64'(ifa.req_ready), 64'd1);

        txn(0, 1, 3'd3, 64'h10, 64'h8877665544332211, 64'd0, 0, 0, 0);
        txn(0, 0, 3'd3, 64'h10, 64'd0, 64'h8877665544332211, 0, 0, 0);
        txn(0, 0, 3'd0, 64'h17, 64'd0, 64'hFFFFFFFFFFFFFF88, 0, 0, 0);
        txn(0, 0, 3'd4, 64'h17, 64'd0, 64'h0000000000000088, 0, 0, 0);
        txn(0, 0, 3'd2, 64'h14, 64'd0, 64'hFFFFFFFF88776655, 0, 0, 0);
        txn(0, 0, 3'd6, 64'h14, 64'd0, 64'h0000000088776655, 0, 0, 0);
        txn(0, 1, 3'd1, 64'h12, 64'hAAAABEEF, 64'd0, 0, 0, 0);
        txn(0, 0, 3'd3, 64'h10, 64'd0, 64'h88776655BEEF2211, 0, 0, 0);
        txn(0, 0, 3'd1, 64'h12, 64'd0, 64'hFFFFFFFFFFFFBEEF, 0, 0, 0);
        txn(0, 0, 3'd5, 64'h16, 64'd0, 64'h0000000000008877, 0, 0, 0);
        txn(0, 0, 3'd2, 64'h13, 64'd0, 64'd0, 1, 0, 0);
        txn(0, 1, 3'd3, 64'(c_BYTES), 64'h1111111111111111, 64'd0, 1, 0, 0);
        txn(0, 0, 3'd3, 64'(c_BYTES - 8), 64'd0, 64'd0, 0, 0, 0);
        txn(0, 0, 3'd7, 64'h10, 64'd0, 64'd0, 1, 0, 0);
        txn(0, 1, 3'd4, 64'h10, 64'h0, 64'd0, 1, 0, 0);
        txn(0, 0, 3'd3, 64'hFFFFFFFFFFFFFFF8, 64'd0, 64'd0, 1, 0, 0);
        txn(0, 1, 3'd0, 64'(c_BYTES - 1), 64'h5A, 64'd0, 0, 0, 0);
        txn(0, 0, 3'd4, 64'(c_BYTES - 1), 64'd0, 64'h5A, 0, 0, 0);
        txn(0, 0, 3'd1, 64'(c_BYTES - 2), 64'd0, 64'h5A00, 0, 0, 0);
        txn(0, 0, 3'd1, 64'(c_BYTES - 1), 64'd0, 64'd0, 1, 0, 0);
        txn(0, 0, 3'd3, 64'(c_BYTES - 8), 64'd0, 64'h5A00000000000000, 0, 0, 0);

        // Backpressure, with a stray store pulse to 0x10 that must be ignored.
        txn(0, 0, 3'd3, 64'h10, 64'd0, 64'h88776655BEEF2211, 0, 5, 0);
        txn(0, 0, 3'd3, 64'h10, 64'd0, 64'h88776655BEEF2211, 0, 0, 0);

        // Reset while the store sits in WAIT.
        @(negedge clk);
        t_sel = 0; t_write = 1; t_funct3 = 3'd3; t_addr = 64'h20; t_wdata = 64'h1234;
        t_valid = 1'b1; t_rr = 1'b1;
        @(posedge clk); #1;
        t_valid = 1'b0;
        check("wait_valid", 64'(ifa.resp_valid), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_valid", 64'(ifa.resp_valid), 64'd0);
        check("abort_ready", 64'(ifa.req_ready), 64'd0);
        @(negedge clk); rst = 1'b0; t_rr = 1'b0;
        txn(0, 0, 3'd3, 64'h20, 64'd0, 64'd0, 0, 0, 0);

        txn(1, 1, 3'd3, 64'h8, 64'hCAFEF00D12345678, 64'd0, 0, 0, 0);
        txn(1, 0, 3'd2, 64'hC, 64'd0, 64'hFFFFFFFFCAFEF00D, 0, 0, 0);
        txn(1, 0, 3'd5, 64'h8, 64'd0, 64'h5678, 0, 0, 0);
        txn(1, 0, 3'd0, 64'(c_BYTES), 64'd0, 64'd0, 1, 0, 0);
        txn(1, 0, 3'd3, 64'h8, 64'd0, 64'hCAFEF00D12345678, 0, 2, 0);

        for (int k = 0; k < 60; k++) begin
            rwr = 1'($urandom_range(0, 1));
            rf  = 3'($urandom_range(0, 7));
            ra  = 64'h7F0 + 64'($urandom_range(0, 32'h81F));
            if ($urandom_range(0, 3) != 0) ra = ra & ~64'((1 << rf[1:0]) - 1);
            rw  = {$urandom, $urandom};
            txn(0, rwr, rf, ra, rw, 64'd0, 0, 0, 1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
